// File: rtl/com_pkg.sv
// rtl/com_pkg.sv - shared types, frame constants and parameter defaults for the COM transmit unit
package com_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_WORDS        = 16;
  localparam int DEF_BASE_ADDR    = 0;
  localparam int DEF_ADDR_STEP    = 4;
  localparam int DEF_CLKS_PER_BIT = 434;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT,
    ST_CSUM_START,
    ST_CSUM_DATA,
    ST_CSUM_STOP,
    ST_DONE
  } com_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } uart_phase_e;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter shared by data and checksum frames
module uart_tx import com_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_byte,
  output logic                 tx,
  output logic                 in_data,
  output logic                 in_stop,
  output logic                 stop_near_end,
  output logic                 frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);

  uart_phase_e            phase_q, phase_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   baud_end;

  assign baud_end      = (baud_q == BAUD_LAST);
  assign tx            = tx_q;
  assign in_data       = (phase_q == PH_DATA);
  assign in_stop       = (phase_q == PH_STOP);
  // Penultimate stop cycle lets the sequencer overlap its bookkeeping with the last stop cycle
  assign stop_near_end = (phase_q == PH_STOP) && (baud_q == BAUD_PENULT);
  assign frame_done    = (phase_q == PH_STOP) && baud_end;

  // Frame sequencing: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles
  always_comb begin
    phase_d = phase_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (phase_q)
      PH_IDLE: begin
        if (load) begin
          phase_d = PH_START;
          tx_d    = START_BIT;
          baud_d  = '0;
          bit_d   = '0;
          shreg_d = load_byte;
        end
      end
      PH_START: begin
        if (baud_end) begin
          baud_d  = '0;
          phase_d = PH_DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      PH_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
          if (bit_q == 3'd7) begin
            phase_d = PH_STOP;
            tx_d    = STOP_BIT;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      PH_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          phase_d = PH_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // Transmitter state registers; line returns to idle-high on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/com_tx_unit.sv
// rtl/com_tx_unit.sv - dumps data memory over UART with a trailing XOR checksum on a COM request
module com_tx_unit import com_pkg::*; #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int WORDS        = DEF_WORDS,
  parameter int BASE_ADDR    = DEF_BASE_ADDR,
  parameter int ADDR_STEP    = DEF_ADDR_STEP,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              com_flag,
  input  logic              end_flag,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              com_done
);

  localparam logic [ADDR_W-1:0] BASE_V   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(ADDR_STEP);
  localparam logic [7:0]        LAST_IDX = 8'(WORDS - 1);

  com_state_e           state_q, state_d;
  logic                 com_flag_q;
  logic [7:0]           index_q, index_d;
  logic                 last_q, last_d;
  logic                 gap_q, gap_d;
  logic [DATA_BITS-1:0] csum_q, csum_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 busy_q, busy_d;
  logic                 com_done_q, com_done_d;

  logic                 load;
  logic [DATA_BITS-1:0] load_byte;
  logic                 in_data, in_stop, stop_near_end, frame_done;
  logic                 com_rise;
  logic                 unused_end_flag;

  // end_flag is informational only: it neither starts nor aborts a transfer
  assign unused_end_flag = end_flag;
  assign com_rise        = com_flag && !com_flag_q;
  assign mem_addr        = mem_addr_q;
  assign busy            = busy_q;
  assign com_done        = com_done_q;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_byte    (load_byte),
    .tx           (tx),
    .in_data      (in_data),
    .in_stop      (in_stop),
    .stop_near_end(stop_near_end),
    .frame_done   (frame_done)
  );

  // Sequencer: NEXT overlaps the last stop cycle so FETCH/WAIT form the two-cycle inter-frame gap
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    last_d     = last_q;
    gap_d      = gap_q;
    csum_d     = csum_q;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    com_done_d = com_done_q;
    load       = 1'b0;
    load_byte  = csum_q;
    case (state_q)
      ST_IDLE: begin
        if (com_rise) begin
          index_d = '0;
          last_d  = 1'b0;
          csum_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last_q) begin
          gap_d   = 1'b0;
          state_d = ST_CSUM_START;
        end else begin
          mem_addr_d = BASE_V + ADDR_W'(index_q) * STEP_V;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        load      = 1'b1;
        load_byte = mem_rdata[DATA_BITS-1:0];
        csum_d    = csum_q ^ mem_rdata[DATA_BITS-1:0];
        if (index_q == LAST_IDX) begin
          last_d = 1'b1;
        end else begin
          index_d = index_q + 8'd1;
        end
        state_d = ST_START;
      end
      ST_START: begin
        if (in_data) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (stop_near_end) state_d = ST_NEXT;
        else if (in_stop)  state_d = ST_STOP;
      end
      ST_STOP: begin
        if (stop_near_end) state_d = ST_NEXT;
      end
      ST_CSUM_START: begin
        if (gap_q) begin
          load    = 1'b1;
          state_d = ST_CSUM_DATA;
        end else begin
          gap_d = 1'b1;
        end
      end
      ST_CSUM_DATA: begin
        if (in_stop) state_d = ST_CSUM_STOP;
      end
      ST_CSUM_STOP: begin
        if (frame_done) begin
          busy_d     = 1'b0;
          com_done_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; com_flag history cleared so a level held through reset still triggers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      com_flag_q <= 1'b0;
      index_q    <= '0;
      last_q     <= 1'b0;
      gap_q      <= 1'b0;
      csum_q     <= '0;
      mem_addr_q <= BASE_V;
      busy_q     <= 1'b0;
      com_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      com_flag_q <= com_flag;
      index_q    <= index_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      csum_q     <= csum_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      com_done_q <= com_done_d;
    end
  end

endmodule

// File: tb/tb_com_tx_unit.sv
// tb/tb_com_tx_unit.sv - self-checking bench for com_tx_unit with a UART receiver and scoreboard
module tb_com_tx_unit;

  localparam int CPB     = 4;
  localparam int TIMEOUT = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        com_flag3, end_flag3, com_flag1, end_flag1;
  logic [31:0] addr3, addr1;
  logic [7:0]  rdata3, rdata1;
  logic        tx3, tx1, busy3, busy1, done3, done1;
  logic [7:0]  mem3 [0:15];
  logic [7:0]  mem1 [0:15];
  logic        sel1;
  logic        tx_s;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q [$];
  int          cyc = 0;
  int          done3_cyc = 0;
  bit          done3_seen = 1'b0;

  assign tx_s = sel1 ? tx1 : tx3;

  com_tx_unit #(
    .ADDR_W(32), .DATA_W(8), .WORDS(3), .BASE_ADDR(0), .ADDR_STEP(4), .CLKS_PER_BIT(CPB)
  ) dut3 (
    .clk(clk), .reset(reset), .com_flag(com_flag3), .end_flag(end_flag3),
    .mem_addr(addr3), .mem_rdata(rdata3), .tx(tx3), .busy(busy3), .com_done(done3)
  );

  com_tx_unit #(
    .ADDR_W(32), .DATA_W(8), .WORDS(1), .BASE_ADDR(0), .ADDR_STEP(4), .CLKS_PER_BIT(CPB)
  ) dut1 (
    .clk(clk), .reset(reset), .com_flag(com_flag1), .end_flag(end_flag1),
    .mem_addr(addr1), .mem_rdata(rdata1), .tx(tx1), .busy(busy1), .com_done(done1)
  );

  always @(posedge clk) begin
    rdata3 <= mem3[addr3[5:2]];
    rdata1 <= mem1[addr1[5:2]];
    cyc    <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!done3_seen && done3 === 1'b1) begin
      done3_seen <= 1'b1;
      done3_cyc  <= cyc;
    end
  end

  // Receives one frame; idle = high samples before the start bit, bad = unstable bit or bad framing
  task automatic rx_frame(output logic [7:0] b, output int idle, output bit bad);
    logic first;
    logic [7:0] v;
    bad  = 1'b0;
    idle = 0;
    v    = 'x;
    while (tx_s !== 1'b0) begin
      if (idle >= TIMEOUT) begin
        bad = 1'b1;
        b   = 'x;
        return;
      end
      idle++;
      @(negedge clk);
    end
    for (int bi = 0; bi < 10; bi++) begin
      first = tx_s;
      for (int k = 0; k < CPB; k++) begin
        if (tx_s !== first) bad = 1'b1;
        @(negedge clk);
      end
      if (bi == 0 && first !== 1'b0) bad = 1'b1;
      if (bi == 9 && first !== 1'b1) bad = 1'b1;
      if (bi >= 1 && bi <= 8) v[bi-1] = first;
    end
    b = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (tx3 !== 1'b1)    begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx3); end
    n_checks++; if (busy3 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy3); end
    n_checks++; if (done3 !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done3); end
    n_checks++; if (addr3 !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr3); end
    n_checks++; if (tx1 !== 1'b1)    begin n_fail++; $display("FAIL reset_tx1: got %b expected 1", tx1); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (tx3 !== 1'b1 || busy3 !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: tx=%b busy=%b expected tx=1 busy=0", tx3, busy3);
    end
  endtask

  task automatic test_transfer();
    logic [7:0] b, e;
    int idle, e0;
    bit bad;
    sel1 = 1'b0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h40);
    com_flag3 = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      rx_frame(b, idle, bad);
      e = exp_q.pop_front();
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL xfer_byte%0d: got %h expected %h", i, b, e); end
      n_checks++; if (idle != (i == 0 ? 4 : 2)) begin n_fail++; $display("FAIL xfer_gap%0d: got %0d expected %0d", i, idle, (i == 0 ? 4 : 2)); end
      n_checks++; if (bad) begin n_fail++; $display("FAIL xfer_timing%0d: got bad bit timing expected clean", i); end
    end
    @(negedge clk);
    n_checks++; if (!done3_seen || (done3_cyc - e0) != 169) begin
      n_fail++; $display("FAIL done_latency: got seen=%0d cycles=%0d expected 169", done3_seen, done3_cyc - e0);
    end
    n_checks++; if (busy3 !== 1'b0 || done3 !== 1'b1) begin
      n_fail++; $display("FAIL xfer_end: got busy=%b done=%b expected busy=0 done=1", busy3, done3);
    end
  endtask

  task automatic test_level_and_retrigger();
    logic [7:0] b, e;
    int idle, lows;
    bit bad;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx3 !== 1'b1 || busy3 !== 1'b0) lows++;
    end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL level_retrigger: got %0d active samples expected 0", lows); end
    com_flag3 = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h40);
    com_flag3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_frame(b, idle, bad);
      e = exp_q.pop_front();
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL retrig_byte%0d: got %h expected %h", i, b, e); end
      n_checks++; if (idle != (i == 0 ? 4 : 2) || bad) begin
        n_fail++; $display("FAIL retrig_timing%0d: got idle=%0d bad=%0d expected idle=%0d bad=0", i, idle, bad, (i == 0 ? 4 : 2));
      end
    end
  endtask

  task automatic test_midpulse();
    logic [7:0] b, e;
    int idle, lows;
    bit bad;
    com_flag3 = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h40);
    com_flag3 = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          rx_frame(b, idle, bad);
          e = exp_q.pop_front();
          n_checks++; if (b !== e || bad) begin n_fail++; $display("FAIL pulse_byte%0d: got %h bad=%0d expected %h", i, b, bad, e); end
          n_checks++; if (busy3 !== (i < 3 ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL pulse_busy%0d: got %b expected %b", i, busy3, (i < 3 ? 1'b1 : 1'b0));
          end
        end
      end
      begin
        repeat (60) @(negedge clk);
        com_flag3 = 1'b0;
        @(negedge clk);
        com_flag3 = 1'b1;
      end
    join
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx3 !== 1'b1 || busy3 !== 1'b0) lows++;
    end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL pulse_no_second: got %0d active samples expected 0", lows); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b, e;
    int idle, waited;
    bit bad;
    com_flag3 = 1'b0;
    repeat (2) @(negedge clk);
    com_flag3 = 1'b1;
    rx_frame(b, idle, bad);
    n_checks++; if (b !== 8'h41 || bad) begin n_fail++; $display("FAIL rmid_first: got %h bad=%0d expected 41", b, bad); end
    waited = 0;
    while (tx3 !== 1'b0 && waited < TIMEOUT) begin waited++; @(negedge clk); end
    n_checks++; if (waited >= TIMEOUT) begin n_fail++; $display("FAIL rmid_second_start: got timeout expected start bit"); end
    repeat (4 * CPB + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (tx3 !== 1'b1)    begin n_fail++; $display("FAIL rmid_tx: got %b expected 1", tx3); end
    n_checks++; if (busy3 !== 1'b0)  begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy3); end
    n_checks++; if (done3 !== 1'b0)  begin n_fail++; $display("FAIL rmid_done: got %b expected 0", done3); end
    n_checks++; if (addr3 !== 32'h0) begin n_fail++; $display("FAIL rmid_addr: got %h expected 0", addr3); end
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h40);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_frame(b, idle, bad);
      e = exp_q.pop_front();
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL restart_byte%0d: got %h expected %h", i, b, e); end
      n_checks++; if (idle != (i == 0 ? 4 : 2) || bad) begin
        n_fail++; $display("FAIL restart_timing%0d: got idle=%0d bad=%0d expected idle=%0d bad=0", i, idle, bad, (i == 0 ? 4 : 2));
      end
    end
    @(negedge clk);
    n_checks++; if (done3 !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b expected 1", done3); end
  endtask

  task automatic test_words1();
    logic [7:0] b, e;
    int idle, lows;
    bit bad;
    sel1 = 1'b1;
    end_flag1 = 1'b1;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) lows++;
    end
    end_flag1 = 1'b0;
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL end_no_start: got %0d active samples expected 0", lows); end
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    com_flag1 = 1'b1;
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          rx_frame(b, idle, bad);
          e = exp_q.pop_front();
          n_checks++; if (b !== e) begin n_fail++; $display("FAIL w1_byte%0d: got %h expected %h", i, b, e); end
          n_checks++; if (idle != (i == 0 ? 4 : 2) || bad) begin
            n_fail++; $display("FAIL w1_timing%0d: got idle=%0d bad=%0d expected idle=%0d bad=0", i, idle, bad, (i == 0 ? 4 : 2));
          end
        end
      end
      begin
        repeat (15) @(negedge clk);
        end_flag1 = 1'b1;
        repeat (3) @(negedge clk);
        end_flag1 = 1'b0;
      end
    join
    @(negedge clk);
    n_checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL w1_end: got done=%b busy=%b expected done=1 busy=0", done1, busy1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem3[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem3[0] = 8'h41; mem3[1] = 8'h42; mem3[2] = 8'h43;
    mem1[0] = 8'hA5;
    reset = 1'b1;
    com_flag3 = 1'b0; end_flag3 = 1'b0;
    com_flag1 = 1'b0; end_flag1 = 1'b0;
    sel1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_transfer();
    test_level_and_retrigger();
    test_midpulse();
    test_reset_mid();
    test_words1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
